multiplicador_secuencial: RTL and testbench



---
 rtl/multiplicador_secuencial_pkg.sv | 11 +
 rtl/multiplicador_secuencial_sumador.sv | 25 ++
 rtl/multiplicador_secuencial.sv | 110 +++++++++++
 tb/tb_multiplicador_secuencial.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_secuencial_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// Holds the controller state encoding.
package multiplicador_secuencial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/multiplicador_secuencial_sumador.sv
// Parametrised structural ripple-carry adder.
// Chain of full adders, reused for the accumulation.
module sumador_nbits #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Carry
);

  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) |
                    (c[i] & (A[i] ^ B[i]));
  end

  assign Carry = c[N];

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-and-add multiplier, WIDTH cycles of
// accumulation plus a sign-fixing cycle, start/done handshake.
module multiplicador_secuencial #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               signo,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  import multiplicador_secuencial_pkg::*;

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;
  logic [WIDTH-1:0] mult;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            load;
  logic            step;
  logic            fin;
  logic            carry_unused;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1).
  assign a_mag = (signo & A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag = (signo & B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  assign addend = mult[0] ? mcand : '0;

  sumador_nbits #(
    .N(PW)
  ) u_sum (
    .A    (acc),
    .B    (addend),
    .Cin  (1'b0),
    .S    (sum),
    .Carry(carry_unused)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: fixed WIDTH iterations, then one sign/write cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (init) state_nx = CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Controller outputs and datapath enables.
  always_comb begin
    busy = (state != IDLE);
    load = (state == IDLE) & init;
    step = (state == CALC);
    fin  = (state == FIN);
  end

  // Datapath: capture, shift-and-add, sign fix into P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      P     <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= PW'(a_mag);
      mult  <= b_mag;
      cnt   <= CW'(WIDTH);
      neg   <= signo & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (step) begin
      acc   <= sum;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt - CW'(1);
    end else if (fin) begin
      P <= neg ? (~acc + PW'(1)) : acc;
    end
  end

  // One-cycle done pulse marking the P update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= fin;
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for the sequential multiplier,
// WIDTH=4 and WIDTH=8 instances.
module tb_multiplicador_secuencial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       init4 = 1'b0;
  logic       signo4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [7:0] p4;
  logic       busy4;
  logic       done4;

  logic        init8 = 1'b0;
  logic        signo8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] p8;
  logic        busy8;
  logic        done8;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last4 = '0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  multiplicador_secuencial #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .init (init4),
    .signo(signo4),
    .A    (a4),
    .B    (b4),
    .P    (p4),
    .busy (busy4),
    .done (done4)
  );

  multiplicador_secuencial #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .init (init8),
    .signo(signo8),
    .A    (a8),
    .B    (b8),
    .P    (p8),
    .busy (busy8),
    .done (done8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op4(input string tag, input logic s,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp_p);
    int lat;
    @(negedge clk);
    init4 = 1'b1; signo4 = s; a4 = a; b4 = b;
    @(posedge clk); #1;
    init4 = 1'b0;
    chk({tag, "_busy"}, busy4, 1);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) chk({tag, "_hold"}, p4, last4);
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_p"}, p4, exp_p);
    chk({tag, "_idle"}, busy4, 0);
    last4 = exp_p;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done4, 0);
  endtask

  task automatic op8(input string tag, input logic s,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp_p);
    int lat;
    @(negedge clk);
    init8 = 1'b1; signo8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    init8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 4) chk({tag, "_hold"}, p8, last8);
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_p"}, p8, exp_p);
    chk({tag, "_idle"}, busy8, 0);
    last8 = exp_p;
  endtask

  initial begin
    int lat;
    int ndone;

    #2;
    chk("rst_p4", p4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_p8", p8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    op4("u15x15", 1'b0, 4'd15, 4'd15, 8'hE1);
    op4("sm3x5", 1'b1, 4'b1101, 4'b0101, 8'hF1);
    op4("sm8xm8", 1'b1, 4'b1000, 4'b1000, 8'h40);
    op4("u9x0", 1'b0, 4'd9, 4'd0, 8'h00);
    op4("s0x7", 1'b1, 4'd0, 4'd7, 8'h00);

    // init pulses at cycles 2 and 3 of a 3*5 run are ignored
    @(negedge clk);
    init4 = 1'b1; signo4 = 1'b0; a4 = 4'd3; b4 = 4'd5;
    @(posedge clk); #1;
    init4 = 1'b0;
    @(posedge clk); #1;
    init4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    init4 = 1'b0;
    lat = 3;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 5);
    chk("ign_p", p4, 8'd15);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("ign_single", ndone, 0);
    chk("ign_busy", busy4, 0);
    last4 = 8'd15;

    // init held through done restarts immediately
    @(negedge clk);
    init4 = 1'b1; signo4 = 1'b0; a4 = 4'd2; b4 = 4'd3;
    @(posedge clk); #1;
    a4 = 4'd4; b4 = 4'd5;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", lat, 5);
    chk("b2b_p1", p4, 8'd6);
    @(posedge clk); #1;
    init4 = 1'b0;
    chk("b2b_busy", busy4, 1);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat2", lat + 1, 6);
    chk("b2b_p2", p4, 8'd20);
    last4 = 8'd20;

    // asynchronous reset in cycle 3 of 7*7
    @(negedge clk);
    init4 = 1'b1; signo4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
    @(posedge clk); #1;
    init4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_p", p4, 0);
    chk("arst_busy", busy4, 0);
    chk("arst_done", done4, 0);
    @(negedge clk);
    rst = 1'b0;
    last4 = '0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("arst_nodone", ndone, 0);
    op4("u7x7", 1'b0, 4'd7, 4'd7, 8'd49);

    op8("w8_255", 1'b0, 8'd255, 8'd255, 16'hFE01);
    op8("w8_neg", 1'b1, 8'h80, 8'h7F, 16'hC080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
